// File: rtl/double_buffer_sum_engine.sv
// -----------------------------------------------------------------------------
// double_buffer_sum_engine
//
// Purpose
//   Component-side engine for a double-buffered agent memory. A host writes
//   one half of a 2*HALF_DEPTH-word RAM through a write-only agent port, while
//   the engine sums the other half on each call. On call acceptance the engine
//   latches db_data (which half to sum), streams HALF_DEPTH reads out of that
//   half, accumulates them and presents the sum on the return interface.
//
// Ports
//   clk               in   single clock, all logic on the rising edge
//   reset_n           in   asynchronous active-low reset
//   avs_a_write       in   agent write strobe (never stalls)
//   avs_a_address     in   word address, MSB selects the half
//   avs_a_writedata   in   write data
//   avs_a_byteenable  in   per-byte write enable
//   db_data           in   half to sum, sampled only when a call is accepted
//   call_valid        in   call request
//   call_stall        out  1 = engine busy, call not accepted
//   return_valid      out  result valid, held until taken
//   return_stall      in   1 = consumer not ready
//   returndata_data   out  sum of the selected half
//
// Build option
//   DBSUM_SATURATE_EN : when defined, the accumulator grows by
//   $clog2(HALF_DEPTH) guard bits and the result saturates to all-ones.
//   When undefined, the accumulator is DATA_W bits and wraps.
// -----------------------------------------------------------------------------
module double_buffer_sum_engine #(
    parameter int DATA_W     = 32,
    parameter int HALF_DEPTH = 256,
    parameter int ADDR_W     = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  avs_a_write,
    input  logic [ADDR_W-1:0]     avs_a_address,
    input  logic [DATA_W-1:0]     avs_a_writedata,
    input  logic [DATA_W/8-1:0]   avs_a_byteenable,
    input  logic                  db_data,
    input  logic                  call_valid,
    output logic                  call_stall,
    output logic                  return_valid,
    input  logic                  return_stall,
    output logic [DATA_W-1:0]     returndata_data
);

    localparam int DEPTH = 2 * HALF_DEPTH;
    localparam int IDX_W = ADDR_W - 1;
    localparam int NB    = DATA_W / 8;
`ifdef DBSUM_SATURATE_EN
    localparam int ACC_W = DATA_W + $clog2(HALF_DEPTH);
`else
    localparam int ACC_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_sel;        // half latched at call acceptance
    logic [IDX_W-1:0]   r_idx;        // word index within the half
    logic               r_rd_valid;   // read data register holds a word to add
    logic [ACC_W-1:0]   r_acc;

    logic [DATA_W-1:0]  w_rdata;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic               w_issue;      // a read is issued this cycle
    logic               w_accept;
    logic               w_last_idx;

    assign w_rd_addr  = {r_sel, r_idx};
    assign w_accept   = call_valid && !call_stall;
    assign w_last_idx = &r_idx;

    // -------------------------------------------------------------------------
    // RAM: one byte-wide array per lane so each lane has its own write enable.
    // Write and read share a lane block; the non-blocking read of the array
    // returns the old word when the agent writes the same address in the same
    // cycle. No reset on the storage or read register so they map to block RAM.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_lane_q;

            always_ff @(posedge clk) begin
                if (avs_a_write && avs_a_byteenable[gi]) begin
                    r_mem[avs_a_address] <= avs_a_writedata[gi*8 +: 8];
                end
                if (w_issue) begin
                    r_lane_q <= r_mem[w_rd_addr];
                end
            end

            assign w_rdata[gi*8 +: 8] = r_lane_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (call_valid)   w_state_next = S_READ;
            S_READ:  if (w_last_idx)   w_state_next = S_DRAIN;
            S_DRAIN:                   w_state_next = S_DONE;
            S_DONE:  if (!return_stall) w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. The engine stalls callers in every state but IDLE, which
    // also keeps a new call from being taken on the same edge as a return.
    // -------------------------------------------------------------------------
    always_comb begin
        call_stall   = 1'b1;
        return_valid = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE:  call_stall   = 1'b0;
            S_READ:  w_issue      = 1'b1;
            S_DONE:  return_valid = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath. The word read on one edge is added on the next, so the final
    // word is absorbed in DRAIN and the accumulator is frozen in DONE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel      <= 1'b0;
            r_idx      <= '0;
            r_rd_valid <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_accept) begin
                r_sel <= db_data;
                r_idx <= '0;
                r_acc <= '0;
            end else begin
                if (w_issue) begin
                    // wraps to zero after the last word of the half
                    r_idx <= r_idx + 1'b1;
                end
                if (r_rd_valid) begin
                    r_acc <= r_acc + ACC_W'(w_rdata);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result
    // -------------------------------------------------------------------------
`ifdef DBSUM_SATURATE_EN
    assign returndata_data = (|r_acc[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : r_acc[DATA_W-1:0];
`else
    assign returndata_data = r_acc;
`endif

endmodule

// File: tb/tb_double_buffer_sum_engine.sv
// -----------------------------------------------------------------------------
// Testbench for double_buffer_sum_engine. A behavioural model (word array plus
// a call/return timeline) is compared against the DUT on every falling edge;
// directed scenarios additionally pin results and latency to literal values.
// -----------------------------------------------------------------------------
module tb_double_buffer_sum_engine;

    localparam int DATA_W     = 32;
    localparam int HALF_DEPTH = 256;
    localparam int ADDR_W     = 9;
    localparam int NB         = DATA_W / 8;
    localparam int H          = HALF_DEPTH;

    logic              clk              = 1'b0;
    logic              reset_n          = 1'b0;
    logic              avs_a_write      = 1'b0;
    logic [ADDR_W-1:0] avs_a_address    = '0;
    logic [DATA_W-1:0] avs_a_writedata  = '0;
    logic [NB-1:0]     avs_a_byteenable = '0;
    logic              db_data          = 1'b0;
    logic              call_valid       = 1'b0;
    logic              call_stall;
    logic              return_valid;
    logic              return_stall     = 1'b0;
    logic [DATA_W-1:0] returndata_data;

    double_buffer_sum_engine #(
        .DATA_W     (DATA_W),
        .HALF_DEPTH (HALF_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .avs_a_write      (avs_a_write),
        .avs_a_address    (avs_a_address),
        .avs_a_writedata  (avs_a_writedata),
        .avs_a_byteenable (avs_a_byteenable),
        .db_data          (db_data),
        .call_valid       (call_valid),
        .call_stall       (call_stall),
        .return_valid     (return_valid),
        .return_stall     (return_stall),
        .returndata_data  (returndata_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model state ----------------
    bit [31:0]   model_mem [2*H];
    bit          m_busy  = 1'b0;
    bit          m_rv    = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_sum   = '0;
    int          acc_edge = 0;
    int          n_acc   = 0;
    int          n_ret   = 0;
    logic [31:0] last_ret = '0;
    bit          prev_rv = 1'b0;
    logic [31:0] res;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h time=%0t", name, got, want, $time);
        end
    endtask

    // Sum of one half straight from the model array.
    function automatic logic [31:0] half_sum(input bit sel);
        longint unsigned s;
        s = 0;
        for (int i = 0; i < H; i++) s += 64'(model_mem[int'(sel) * H + i]);
`ifdef DBSUM_SATURATE_EN
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
        return s[31:0];
`endif
    endfunction

    // Compare process: check outputs against the model, then advance the
    // model by what the coming rising edge will do.
    always @(negedge clk) begin
        if (!reset_n) begin
            check32("rst_call_stall", 32'(call_stall), 32'd0);
            check32("rst_return_valid", 32'(return_valid), 32'd0);
            check32("rst_returndata", returndata_data, 32'd0);
            m_busy  = 1'b0;
            m_rv    = 1'b0;
            m_cnt   = 0;
            prev_rv = 1'b0;
        end else begin
            check32("call_stall", 32'(call_stall), 32'(m_busy));
            check32("return_valid", 32'(return_valid), 32'(m_rv));
            if (m_rv) check32("returndata", returndata_data, m_sum);
            if (return_valid && !prev_rv) check32("latency", 32'(cyc + 1 - acc_edge), 32'(H + 2));
            prev_rv = return_valid;

            if (avs_a_write) begin
                for (int b = 0; b < NB; b++) begin
                    if (avs_a_byteenable[b]) model_mem[avs_a_address][b*8 +: 8] = avs_a_writedata[b*8 +: 8];
                end
            end

            if (!m_busy) begin
                if (call_valid) begin
                    m_busy   = 1'b1;
                    m_sum    = half_sum(db_data);
                    m_cnt    = H + 1;
                    acc_edge = cyc + 1;
                    n_acc++;
                end
            end else if (!m_rv) begin
                m_cnt--;
                if (m_cnt == 0) m_rv = 1'b1;
            end else if (!return_stall) begin
                m_rv     = 1'b0;
                m_busy   = 1'b0;
                last_ret = returndata_data;
                n_ret++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [31:0] data, input logic [3:0] be);
        avs_a_write      = 1'b1;
        avs_a_address    = ADDR_W'(addr);
        avs_a_writedata  = data;
        avs_a_byteenable = be;
        tick();
        avs_a_write      = 1'b0;
    endtask

    task automatic do_call(input bit sel, input int stall, input bit hold, output logic [31:0] r);
        int a0, r0, k;
        a0 = n_acc;
        r0 = n_ret;
        db_data      = sel;
        call_valid   = 1'b1;
        return_stall = (stall > 0);
        k = 0;
        while (n_acc == a0 && k < 20) begin tick(); k++; end
        check32("accepted", 32'(n_acc - a0), 32'd1);
        if (hold) begin
            // keep requesting and wiggle db_data while the sum runs
            for (int i = 0; i < 100; i++) begin
                if (i % 7 == 3) db_data = ~db_data;
                tick();
            end
            call_valid = 1'b0;
            check32("single_accept", 32'(n_acc - a0), 32'd1);
        end else begin
            call_valid = 1'b0;
        end
        if (stall > 0) begin
            k = 0;
            while (!return_valid && k < 600) begin tick(); k++; end
            repeat (stall) tick();
            check32("no_early_transfer", 32'(n_ret - r0), 32'd0);
            check32("rv_held", 32'(return_valid), 32'd1);
            check32("stall_in_done", 32'(call_stall), 32'd1);
            return_stall = 1'b0;
        end
        k = 0;
        while (n_ret == r0 && k < 700) begin tick(); k++; end
        tick();
        tick();
        check32("one_return", 32'(n_ret - r0), 32'd1);
        r = last_ret;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int a0;
        #1;
        check32("init_call_stall", 32'(call_stall), 32'd0);
        check32("init_return_valid", 32'(return_valid), 32'd0);
        check32("init_returndata", returndata_data, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // 1: half 0 holds 0..255
        for (int i = 0; i < H; i++) write_word(i, 32'(i), 4'hF);
        do_call(1'b0, 0, 1'b0, res);
        check32("t1_sum_half0", res, 32'd32640);

        // 2: fill half 1 while summing half 0, then sum half 1
        fork
            do_call(1'b0, 0, 1'b0, res);
            for (int i = 0; i < H; i++) write_word(H + i, 32'(H + i), 4'hF);
        join
        check32("t2_sum_half0", res, 32'd32640);
        do_call(1'b1, 0, 1'b0, res);
        check32("t2_sum_half1", res, 32'd98176);

        // 3: consumer stalls for 10 cycles in DONE
        do_call(1'b1, 10, 1'b0, res);
        check32("t3_stalled_sum", res, 32'd98176);

        // 4: call held through READ with db_data toggling
        do_call(1'b0, 0, 1'b1, res);
        check32("t4_latched_half", res, 32'd32640);

        // 5: all-ones half 0
        for (int i = 0; i < H; i++) write_word(i, 32'hFFFF_FFFF, 4'hF);
        do_call(1'b0, 0, 1'b0, res);
`ifdef DBSUM_SATURATE_EN
        check32("t5_all_ones", res, 32'hFFFF_FFFF);
`else
        check32("t5_all_ones", res, 32'hFFFF_FF00);
`endif

        // 6: partial byte write into an otherwise zero half
        for (int i = 0; i < H; i++) write_word(i, 32'd0, 4'hF);
        write_word(0, 32'h1111_1111, 4'hF);
        write_word(0, 32'hAABB_CCDD, 4'b0011);
        do_call(1'b0, 0, 1'b0, res);
        check32("t6_byteenable", res, 32'h1111_CCDD);

        // 6b: reset in the middle of READ aborts the call
        a0 = n_acc;
        db_data    = 1'b1;
        call_valid = 1'b1;
        for (int k = 0; k < 20 && n_acc == a0; k++) tick();
        call_valid = 1'b0;
        repeat (50) tick();
        check32("mid_read_busy", 32'(call_stall), 32'd1);
        reset_n = 1'b0;
        #1;
        check32("abort_call_stall", 32'(call_stall), 32'd0);
        check32("abort_return_valid", 32'(return_valid), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        do_call(1'b0, 0, 1'b0, res);
        check32("after_reset_sum", res, 32'h1111_CCDD);

        // random: scattered writes, then a call racing writes to the idle half
        for (int it = 0; it < 12; it++) begin
            bit sel;
            int st;
            sel = 1'($urandom_range(0, 1));
            st  = $urandom_range(0, 4);
            repeat (6) write_word($urandom_range(0, 2*H - 1), $urandom, 4'($urandom));
            fork
                do_call(sel, st, 1'b0, res);
                begin
                    int n;
                    n = $urandom_range(0, 150);
                    for (int j = 0; j < n; j++)
                        write_word(int'(!sel) * H + $urandom_range(0, H - 1), $urandom, 4'($urandom));
                end
            join
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
